// File: rtl/div_mnbit.sv
// Sequential unsigned restoring divider: (M+N)-bit dividend / N-bit divisor,
// one quotient bit per clock, start/busy/done handshake with error flags.
module div_mnbit #(
    parameter int M = 4,
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [M+N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic [M-1:0]     quotient,
    output logic [N-1:0]     remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(M + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [M-1:0]    low_q, low_d;
    logic [N-1:0]    dvs_q, dvs_d;
    logic [N:0]      rem_q, rem_d;
    logic [M-1:0]    quo_q, quo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [M-1:0]    quotient_q, quotient_d;
    logic [N-1:0]    remainder_q, remainder_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            accept_s;
    logic [N:0]      r_shift_s;
    logic [N:0]      r_sub_s;
    logic            fits_s;
    logic [M-1:0]    quo_next_s;

    // Low dividend bits are consumed MSB-first by shifting them out of low_q.
    assign accept_s   = start && (state_q != S_RUN);
    assign r_shift_s  = {rem_q[N-1:0], low_q[M-1]};
    assign fits_s     = (r_shift_s >= {1'b0, dvs_q});
    assign r_sub_s    = r_shift_s - {1'b0, dvs_q};
    assign quo_next_s = {quo_q[M-2:0], fits_s};

    // Next-state and datapath computation for every register.
    always_comb begin
        state_d     = state_q;
        low_d       = low_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    low_d = dividend[M-1:0];
                    dvs_d = divisor;
                    dbz_d = 1'b0;
                    ovf_d = 1'b0;
                    if (divisor == {N{1'b0}}) begin
                        dbz_d       = 1'b1;
                        ovf_d       = 1'b1;
                        state_d     = S_DONE;
                        quotient_d  = {M{1'b1}};
                        remainder_d = {N{1'b0}};
                    end else if (dividend[M+N-1:M] >= divisor) begin
                        ovf_d       = 1'b1;
                        state_d     = S_DONE;
                        quotient_d  = {M{1'b1}};
                        remainder_d = {N{1'b0}};
                    end else begin
                        state_d = S_RUN;
                        rem_d   = {1'b0, dividend[M+N-1:M]};
                        quo_d   = {M{1'b0}};
                        cnt_d   = CW'(M);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                rem_d = fits_s ? r_sub_s : r_shift_s;
                quo_d = quo_next_s;
                low_d = {low_q[M-2:0], 1'b0};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d     = S_DONE;
                    quotient_d  = quo_next_s;
                    remainder_d = rem_d[N-1:0];
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            low_q       <= {M{1'b0}};
            dvs_q       <= {N{1'b0}};
            rem_q       <= {(N+1){1'b0}};
            quo_q       <= {M{1'b0}};
            cnt_q       <= {CW{1'b0}};
            quotient_q  <= {M{1'b0}};
            remainder_q <= {N{1'b0}};
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            low_q       <= low_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_div_mnbit.sv
// Randomized self-checking bench for div_mnbit against an arithmetic reference.
module tb_div_mnbit;

    localparam int M = 4;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [M+N-1:0] dividend = '0;
    logic [N-1:0]   divisor = '0;
    logic           busy;
    logic           done;
    logic [M-1:0]   quotient;
    logic [N-1:0]   remainder;
    logic           div_by_zero;
    logic           overflow;

    int n_cmp = 0;
    int n_err = 0;

    div_mnbit #(.M(M), .N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer division, saturated on error.
    task automatic model(input int a, input int b, output int q, output int r,
                         output int dz, output int ov, output int lat);
        dz = (b == 0) ? 1 : 0;
        ov = (b == 0 || (a / b) >= (1 << M)) ? 1 : 0;
        if (ov != 0) begin
            q = (1 << M) - 1;
            r = 0;
            lat = 1;
        end else begin
            q = a / b;
            r = a % b;
            lat = M + 1;
        end
    endtask

    // Waits (bounded) for done; scrambles inputs after accept, optionally pulses start mid-RUN.
    task automatic wait_done(input bit pulse, output int lat, output int nb);
        lat = 0;
        nb = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            dividend = (M+N)'($urandom);
            divisor = N'($urandom);
            if (pulse && i == 2) start = 1'b1;
            if (busy) nb++;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic check_res(input string tag, input int a, input int b, input int lat, input int nb);
        int q, r, dz, ov, el;
        model(a, b, q, r, dz, ov, el);
        chk({tag, "_lat"}, lat, el);
        chk({tag, "_busy"}, nb, el - 1);
        chk({tag, "_q"}, quotient, q);
        chk({tag, "_r"}, remainder, r);
        chk({tag, "_dz"}, div_by_zero, dz);
        chk({tag, "_ov"}, overflow, ov);
    endtask

    task automatic do_op(input string tag, input int a, input int b, input bit pulse);
        int lat, nb, q, r, dz, ov, el;
        model(a, b, q, r, dz, ov, el);
        @(negedge clk);
        dividend = (M+N)'(a);
        divisor = N'(b);
        start = 1'b1;
        wait_done(pulse && (ov == 0), lat, nb);
        check_res(tag, a, b, lat, nb);
        @(negedge clk);
        chk({tag, "_done1"}, done, 0);
        chk({tag, "_hold"}, quotient, q);
    endtask

    initial begin
        int lat, nb, a, b;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dz", div_by_zero, 0);
        chk("rst_ov", overflow, 0);
        rst_n = 1'b1;

        do_op("d143_13", 143, 13, 1'b0);
        do_op("d100_0", 100, 0, 1'b0);
        do_op("d240_15", 240, 15, 1'b0);
        do_op("mid_start", 143, 13, 1'b1);

        // Back-to-back: start held in DONE launches the next operation.
        @(negedge clk);
        dividend = 8'd200;
        divisor = 4'd15;
        start = 1'b1;
        wait_done(1'b0, lat, nb);
        check_res("b2b_a", 200, 15, lat, nb);
        dividend = 8'd37;
        divisor = 4'd5;
        start = 1'b1;
        wait_done(1'b0, lat, nb);
        check_res("b2b_b", 37, 5, lat, nb);
        @(negedge clk);
        chk("b2b_done1", done, 0);

        // Reset mid-RUN clears outputs at once and suppresses done.
        @(negedge clk);
        dividend = 8'd200;
        divisor = 4'd15;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("run_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_q", quotient, 0);
        chk("arst_r", remainder, 0);
        chk("arst_dz", div_by_zero, 0);
        chk("arst_ov", overflow, 0);
        nb = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) nb++;
        end
        chk("arst_quiet", nb, 0);
        rst_n = 1'b1;
        do_op("post_rst", 143, 13, 1'b0);

        // Round trip with the multiplier: (A*B)/B.
        for (int ai = 0; ai < (1 << M); ai++) begin
            for (int bi = 1; bi < (1 << N); bi++) begin
                do_op("rt", ai * bi, bi, 1'b0);
            end
        end

        for (int k = 0; k < 200; k++) begin
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, (1 << N) - 1));
            if ($urandom_range(0, 1) == 0 || b == 0)
                a = int'($urandom_range(0, (1 << (M + N)) - 1));
            else
                a = int'($urandom_range(0, (1 << M) - 1)) * b + int'($urandom_range(0, b - 1));
            do_op("rnd", a, b, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div_mnbit.md
Name: div_mnbit

Overview:
- Sequential unsigned restoring divider; inverse of mult_mnbit.
- Divides an (M+N)-bit dividend (product width) by an N-bit divisor, producing an M-bit quotient and an N-bit remainder.
- Retires one quotient bit per clock, with a start/busy/done handshake.
- Used to check multiplier results and as the datapath divide unit.

Parameters:
- M, 4, quotient width (matches mult_mnbit A width); M >= 2
- N, 4, divisor/remainder width (matches mult_mnbit B width); N >= 2

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when busy=0
- dividend  input  M+N  unsigned dividend, sampled on accept edge
- divisor  input  N  unsigned divisor, sampled on accept edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; results valid from this cycle on
- quotient  output  M  unsigned quotient
- remainder  output  N  unsigned remainder
- div_by_zero  output  1  captured divisor was 0
- overflow  output  1  true quotient does not fit in M bits

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, quotient, remainder, div_by_zero and overflow all 0; internal counter and registers cleared. Applies immediately, including mid-RUN; the in-flight operation is discarded and no done is issued.
- States: IDLE, RUN, DONE.
- Accept: start=1 at a rising edge while state is IDLE or DONE. start during RUN is ignored (not queued). Back-to-back operations are allowed from DONE.
- On accept:
  - Latch dividend and divisor into internal registers; later input changes have no effect.
  - Clear div_by_zero and overflow.
  - Error check on latched values:
    - divisor==0 -> div_by_zero=1, overflow=1.
    - else dividend[M+N-1:M] >= divisor -> overflow=1.
    - Either error: next state DONE; quotient = all ones; remainder = 0.
  - Otherwise: next state RUN; R (N+1 bits) = {1'b0, dividend[M+N-1:M]}; Q = 0; count = M.
- RUN, each edge (bit k from M-1 down to 0):
  - R' = {R[N-1:0], dividend[k]}.
  - If R' >= {1'b0, divisor}: R = R' - divisor, Q bit k = 1.
  - Else: R = R', Q bit k = 0.
  - Decrement count; the edge processing bit 0 moves state to DONE.
- Invariant: R < divisor before each shift, so R never exceeds N+1 bits.
- Latency (accept at edge t0):
  - Normal: done=1 in the cycle after edge t0+M.
  - Error: done=1 in the cycle after edge t0.
- On entering DONE: quotient = Q (M bits), remainder = R[N-1:0].
- DONE lasts exactly one cycle. done=1 only in DONE; busy=1 only in RUN. Next state is IDLE, or RUN/DONE if start is accepted in DONE.
- Outputs (quotient, remainder, flags) hold their values after DONE until the next accept. Flags clear on accept; quotient and remainder update only on entry to DONE.
- Correctness on non-error paths: dividend == quotient*divisor + remainder, and remainder < divisor.

Test Plan (M=N=4):
- Normal divide: dividend=143, divisor=13, start pulse -> busy high 4 cycles; done pulse after edge t0+4; quotient=11, remainder=0, flags 0.
- Nonzero remainder and back-to-back: 200/15 then 37/5 with start held during DONE -> quotient=13, remainder=5; then quotient=7, remainder=2; exactly one done pulse per operation.
- Errors: 100/0 -> done after 1 edge, div_by_zero=1, overflow=1, quotient=15, remainder=0. 240/15 -> overflow=1, div_by_zero=0, quotient=15.
- Protocol: start pulsed mid-RUN and dividend/divisor changed mid-RUN -> ignored, result matches values latched at accept. rst_n low mid-RUN -> all outputs 0 immediately, no done; a new start after release works normally.
- Round-trip with mult_mnbit: all A in 0..15, B in 1..15 -> divide product by B gives quotient=A, remainder=0, overflow=0.
